// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritising maskable + NMI interrupt controller
// Edge-detects requests, arbitrates lowest unmasked index, handshakes via INT/NMI/INTD.
module interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmiReq,
  input  logic               maskWe,
  input  logic [NUM_IRQ-1:0] maskData,
  input  logic               isInterrupted,
  input  logic               INA,
  input  logic               eoi,
  input  logic               nmiEoi,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [VEC_W-1:0]   vector,
  output logic               vectorValid,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_SERVICE} m_state_t;
  typedef enum logic [1:0] {N_IDLE, N_REQ, N_SERVICE} n_state_t;

  m_state_t           m_state, m_next;
  n_state_t           n_state, n_next;
  logic [NUM_IRQ-1:0] irq_q, mask, unmasked, clr, pend_next;
  logic               nmi_q, nmi_pend, nmi_take, nmi_pend_next, has_req, m_ack;
  logic [VEC_W-1:0]   sel;

  always_comb begin
    unmasked = pending & ~mask;
    has_req  = |unmasked;
    sel      = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (unmasked[i]) sel = VEC_W'(i);
    end

    m_next = m_state;
    m_ack  = 1'b0;
    clr    = '0;
    case (m_state)
      M_IDLE:    if (has_req) m_next = M_REQ;
      M_REQ: begin
        if (!has_req) begin
          m_next = M_IDLE;
        end else if (isInterrupted && INA) begin
          m_next = M_SERVICE;
          m_ack  = 1'b1;
          clr    = NUM_IRQ'(1) << sel;
        end
      end
      M_SERVICE: if (eoi) m_next = M_IDLE;
      default:   m_next = M_IDLE;
    endcase

    // nmi_pend is consumed when NMI is raised so edges arriving during
    // N_REQ/N_SERVICE are remembered once and re-request after nmiEoi.
    n_next   = n_state;
    nmi_take = 1'b0;
    case (n_state)
      N_IDLE: if (nmi_pend) begin
        n_next   = N_REQ;
        nmi_take = 1'b1;
      end
      N_REQ:     if (isInterrupted && !INA) n_next = N_SERVICE;
      N_SERVICE: if (nmiEoi) n_next = N_IDLE;
      default:   n_next = N_IDLE;
    endcase

    // New edges win over a same-cycle acknowledge clear.
    pend_next     = (pending & ~clr) | (irq & ~irq_q);
    nmi_pend_next = (nmi_pend & ~nmi_take) | (nmiReq & ~nmi_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state     <= M_IDLE;
      n_state     <= N_IDLE;
      irq_q       <= '0;
      nmi_q       <= 1'b0;
      mask        <= '1;
      nmi_pend    <= 1'b0;
      pending     <= '0;
      INT         <= 1'b0;
      NMI         <= 1'b0;
      INTD        <= 1'b0;
      vector      <= '0;
      vectorValid <= 1'b0;
    end else begin
      m_state     <= m_next;
      n_state     <= n_next;
      irq_q       <= irq;
      nmi_q       <= nmiReq;
      nmi_pend    <= nmi_pend_next;
      pending     <= pend_next;
      if (maskWe) mask <= maskData;
      if (m_ack) vector <= sel;
      INT         <= (m_next == M_REQ);
      NMI         <= (n_next == N_REQ);
      INTD        <= (m_next == M_SERVICE) || (n_next == N_SERVICE);
      vectorValid <= (m_next == M_SERVICE);
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed bench for interrupt_controller
module tb_interrupt_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic       nmiReq, maskWe, isInterrupted, INA, eoi, nmiEoi;
  logic [7:0] maskData;
  logic       INT, NMI, INTD, vectorValid;
  logic [2:0] vector;
  logic [7:0] pending;
  int total = 0;
  int bad   = 0;

  interrupt_controller #(.NUM_IRQ(8), .VEC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .nmiReq(nmiReq), .maskWe(maskWe),
    .maskData(maskData), .isInterrupted(isInterrupted), .INA(INA), .eoi(eoi),
    .nmiEoi(nmiEoi), .INT(INT), .NMI(NMI), .INTD(INTD), .vector(vector),
    .vectorValid(vectorValid), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; nmiReq = 0; maskWe = 0; maskData = '0;
    isInterrupted = 0; INA = 0; eoi = 0; nmiEoi = 0;
    tick(); tick();
    chk("rst_INT", INT, 0);   chk("rst_NMI", NMI, 0);   chk("rst_INTD", INTD, 0);
    chk("rst_vec", vector, 0); chk("rst_vv", vectorValid, 0); chk("rst_pend", pending, 0);
    rst_n = 1'b1;
    tick();

    // single line 5
    maskWe = 1; maskData = 8'h00; tick(); maskWe = 0;
    irq = 8'h20; tick();
    chk("t1_pend", pending, 8'h20); chk("t1_INT_early", INT, 0);
    irq = 8'h00; tick();
    chk("t1_INT", INT, 1);
    isInterrupted = 1; INA = 1; tick(); isInterrupted = 0;
    chk("t1_ack_INT", INT, 0); chk("t1_ack_INTD", INTD, 1); chk("t1_vec", vector, 5);
    chk("t1_vv", vectorValid, 1); chk("t1_ack_pend", pending, 0);
    tick();
    chk("t1_svc_INT", INT, 0);
    eoi = 1; tick(); eoi = 0;
    chk("t1_eoi_INTD", INTD, 0); chk("t1_eoi_vv", vectorValid, 0); chk("t1_eoi_vec", vector, 5);

    // lines 6 and 2 together
    irq = 8'h44; tick();
    chk("t2_pend", pending, 8'h44);
    irq = 8'h00; tick();
    chk("t2_INT", INT, 1);
    isInterrupted = 1; INA = 1; tick(); isInterrupted = 0;
    chk("t2_vec_a", vector, 2); chk("t2_pend_a", pending, 8'h40);
    eoi = 1; tick(); eoi = 0;
    chk("t2_eoi_INT", INT, 0);
    tick();
    chk("t2_reINT", INT, 1);
    isInterrupted = 1; INA = 1; tick(); isInterrupted = 0;
    chk("t2_vec_b", vector, 6); chk("t2_pend_b", pending, 0);
    eoi = 1; tick(); eoi = 0;

    // masked line 3
    maskWe = 1; maskData = 8'h08; tick(); maskWe = 0;
    irq = 8'h08; tick();
    chk("t3_pend", pending, 8'h08);
    irq = 8'h00; tick(); tick();
    chk("t3_masked_INT", INT, 0);
    maskWe = 1; maskData = 8'h00; tick(); maskWe = 0;
    chk("t3_wr_INT", INT, 0);
    tick();
    chk("t3_unmask_INT", INT, 1);
    isInterrupted = 1; INA = 1; tick(); isInterrupted = 0;
    chk("t3_vec", vector, 3);
    eoi = 1; tick(); eoi = 0;

    // NMI preempts acknowledge while line 1 requests
    irq = 8'h02; tick(); irq = 8'h00; tick();
    chk("t4_INT", INT, 1);
    nmiReq = 1; tick(); nmiReq = 0; tick();
    chk("t4_NMI", NMI, 1); chk("t4_INT_hold", INT, 1);
    isInterrupted = 1; INA = 0; tick(); isInterrupted = 0;
    chk("t4_nack_NMI", NMI, 0); chk("t4_nack_INTD", INTD, 1); chk("t4_nack_INT", INT, 1);
    nmiEoi = 1; tick(); nmiEoi = 0;
    chk("t4_neoi_INTD", INTD, 0);
    isInterrupted = 1; INA = 1; tick(); isInterrupted = 0;
    chk("t4_vec", vector, 1); chk("t4_vv", vectorValid, 1);

    // no nesting during service
    irq = 8'h01; tick();
    chk("t5_pend", pending, 8'h01); chk("t5_INT", INT, 0);
    irq = 8'h00; tick();
    chk("t5_INT_b", INT, 0);
    eoi = 1; tick(); eoi = 0;
    chk("t5_eoi_vv", vectorValid, 0);
    tick();
    chk("t5_reINT", INT, 1);
    isInterrupted = 1; INA = 1; tick(); isInterrupted = 0;
    chk("t5_vec", vector, 0);

    // async reset mid-service
    irq = 8'h10; tick(); irq = 8'h00;
    chk("t6_pend_pre", pending, 8'h10);
    #2 rst_n = 1'b0; #1;
    chk("t6_INT", INT, 0); chk("t6_NMI", NMI, 0); chk("t6_INTD", INTD, 0);
    chk("t6_vv", vectorValid, 0); chk("t6_pend", pending, 0);
    tick(); rst_n = 1'b1; tick(); tick();
    chk("t6_rel_INT", INT, 0); chk("t6_rel_NMI", NMI, 0);
    irq = 8'h80; tick(); irq = 8'h00;
    chk("t6_mask_pend", pending, 8'h80);
    tick(); tick();
    chk("t6_mask_INT", INT, 0);

    // NMI edge during N_SERVICE re-raises after nmiEoi
    nmiReq = 1; tick(); nmiReq = 0; tick();
    chk("t7_NMI", NMI, 1);
    isInterrupted = 1; INA = 0; tick(); isInterrupted = 0;
    chk("t7_INTD", INTD, 1);
    nmiReq = 1; tick(); nmiReq = 0; tick();
    chk("t7_svc_NMI", NMI, 0);
    nmiEoi = 1; tick(); nmiEoi = 0;
    chk("t7_eoi_NMI", NMI, 0); chk("t7_eoi_INTD", INTD, 0);
    tick();
    chk("t7_reNMI", NMI, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
